// File: rtl/fetch_sequencer_pkg.sv
// fetch_sequencer_pkg: state encoding, default vectors and opcode helpers for the fetch sequencer
package fetch_sequencer_pkg;
  typedef enum logic [3:0] {
    FETCH0 = 4'd0,
    FETCH1 = 4'd1,
    FETCH2 = 4'd2,
    DECODE = 4'd3,
    PTR_LO = 4'd4,
    PTR_HI = 4'd5,
    OPR_LO = 4'd6,
    OPR_HI = 4'd7,
    EXEC   = 4'd8,
    HALTED = 4'd9
  } state_t;
  localparam logic [15:0] DEF_RESET_PC    = 16'h0000;
  localparam logic [15:0] DEF_TRAP_VECTOR = 16'h0010;
  localparam logic [1:0]  SRC_DATA        = 2'b01;
  function automatic logic has_data_byte(input logic [7:0] op);
    return op[7:6] == 2'b10 && op[2:1] == SRC_DATA;
  endfunction
endpackage

// File: rtl/fetch_sequencer_mem_byte_port.sv
// fetch_sequencer_mem_byte_port: registered byte-bus request with a completion pulse on req & ack
module fetch_sequencer_mem_byte_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue,
  input  logic [15:0] nxt_addr,
  input  logic        nxt_we,
  input  logic [7:0]  nxt_wdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        done
);
  assign done = mem_req & mem_ack;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
    end else if (issue) begin
      mem_req   <= 1'b1;
      mem_we    <= nxt_we;
      mem_addr  <= nxt_addr;
      mem_wdata <= nxt_wdata;
    end else if (done) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: multi-cycle fetch/operand/execute control FSM owning the program counter
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [15:0] TRAP_VECTOR = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] inst,
  output logic [7:0]  data,
  output logic        dec_en,
  input  logic [1:0]  dec_bytes,
  input  logic        dec_source_ram,
  input  logic        dec_source_indirect,
  input  logic        dec_store,
  input  logic        dec_halt,
  input  logic        dec_trap,
  input  logic [15:0] ea,
  input  logic [15:0] store_val,
  output logic [15:0] operand,
  output logic        exec,
  input  logic        pc_load,
  input  logic [15:0] pc_target,
  output logic [15:0] pc,
  output logic        halted
);
  state_t      state, state_nxt;
  logic        done, issue, nxt_we, store_q, fetch2_q;
  logic [15:0] nxt_addr, pc_nxt;
  logic [7:0]  nxt_wdata, ptr_lo;
  fetch_sequencer_mem_byte_port u_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .issue     (issue),
    .nxt_addr  (nxt_addr),
    .nxt_we    (nxt_we),
    .nxt_wdata (nxt_wdata),
    .mem_ack   (mem_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done)
  );
  assign pc_nxt = dec_trap ? TRAP_VECTOR :
                  pc_load  ? pc_target   :
                  pc + {14'b0, dec_bytes} + {15'b0, fetch2_q};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH0;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      FETCH0:  if (done) state_nxt = mem_rdata[7] ? FETCH1 : DECODE;
      FETCH1:  if (done) state_nxt = has_data_byte(inst[15:8]) ? FETCH2 : DECODE;
      FETCH2:  if (done) state_nxt = DECODE;
      DECODE:  state_nxt = dec_source_indirect ? PTR_LO :
                           (dec_source_ram || dec_store) ? OPR_LO : EXEC;
      PTR_LO:  if (done) state_nxt = PTR_HI;
      PTR_HI:  if (done) state_nxt = OPR_LO;
      OPR_LO:  if (done) state_nxt = OPR_HI;
      OPR_HI:  if (done) state_nxt = EXEC;
      EXEC:    state_nxt = dec_halt ? HALTED : FETCH0;
      default: state_nxt = HALTED;
    endcase
  end
  // Next transfer is loaded on the completing edge so back-to-back bus states keep mem_req high
  always_comb begin
    exec      = state == EXEC;
    dec_en    = state == DECODE || state == EXEC;
    halted    = state == HALTED;
    issue     = 1'b0;
    nxt_addr  = mem_addr + 16'd1;
    nxt_we    = 1'b0;
    nxt_wdata = 8'h00;
    case (state)
      FETCH0: begin
        issue    = (!mem_req && run) || (done && mem_rdata[7]);
        nxt_addr = mem_req ? mem_addr + 16'd1 : pc;
      end
      FETCH1: issue = done && has_data_byte(inst[15:8]);
      DECODE: begin
        issue     = dec_source_indirect || dec_source_ram || dec_store;
        nxt_addr  = ea;
        nxt_we    = dec_store && !dec_source_indirect;
        nxt_wdata = store_val[7:0];
      end
      PTR_LO: issue = done;
      PTR_HI: begin
        issue     = done;
        nxt_addr  = {mem_rdata, ptr_lo};
        nxt_we    = store_q;
        nxt_wdata = store_val[7:0];
      end
      OPR_LO: begin
        issue     = done;
        nxt_we    = store_q;
        nxt_wdata = store_val[15:8];
      end
      EXEC: begin
        issue    = run && !dec_halt;
        nxt_addr = pc_nxt;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RESET_PC;
      inst     <= 16'h0000;
      data     <= 8'h00;
      operand  <= 16'h0000;
      ptr_lo   <= 8'h00;
      store_q  <= 1'b0;
      fetch2_q <= 1'b0;
    end else begin
      if (done && state == FETCH0) begin
        inst     <= {mem_rdata, 8'h00};
        data     <= 8'h00;
        fetch2_q <= 1'b0;
      end
      if (done && state == FETCH1) inst[7:0] <= mem_rdata;
      if (done && state == FETCH2) begin
        data     <= mem_rdata;
        fetch2_q <= 1'b1;
      end
      if (state == DECODE) store_q <= dec_store;
      if (done && state == PTR_LO) ptr_lo <= mem_rdata;
      if (done && state == OPR_LO && !store_q) operand[7:0] <= mem_rdata;
      if (done && state == OPR_HI && !store_q) operand[15:8] <= mem_rdata;
      if (state == EXEC) pc <= pc_nxt;
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized instruction stream checked against a transaction-level model
module tb_fetch_sequencer;
  logic        clk, rst_n, run;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [15:0] inst, operand, pc, ea, store_val, pc_target;
  logic [7:0]  data;
  logic        dec_en, exec, halted, pc_load;
  logic [1:0]  dec_bytes;
  logic        dec_source_ram, dec_source_indirect, dec_store, dec_halt, dec_trap;
  logic [7:0]  mem [0:65535];
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];
  logic [15:0] mpc, m_opnd, stall_addr;
  logic        noise, stall_en;
  int          w_lo, w_hi;
  int          errs = 0;
  int          checks = 0;
  fetch_sequencer #(.RESET_PC(16'h0000), .TRAP_VECTOR(16'h0010)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .inst(inst), .data(data), .dec_en(dec_en), .dec_bytes(dec_bytes),
    .dec_source_ram(dec_source_ram), .dec_source_indirect(dec_source_indirect),
    .dec_store(dec_store), .dec_halt(dec_halt), .dec_trap(dec_trap),
    .ea(ea), .store_val(store_val), .operand(operand), .exec(exec),
    .pc_load(pc_load), .pc_target(pc_target), .pc(pc), .halted(halted)
  );
  // Toy decoder: bit 7 selects 2-byte form, bits 2:1 the source, bit 3 store
  assign dec_bytes           = inst[15] ? 2'd2 : 2'd1;
  assign dec_source_ram      = inst[15] && inst[10:9] == 2'b10;
  assign dec_source_indirect = inst[15] && inst[10:9] == 2'b11;
  assign dec_store           = inst[15] && inst[11] && inst[10];
  assign dec_halt            = inst[15:8] == 8'h01;
  assign dec_trap            = inst[15:8] == 8'h02;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  initial begin
    logic        busy;
    int          wl;
    logic [24:0] held;
    busy = 1'b0;
    wl = 0;
    held = '0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (!mem_req) begin
        busy = 1'b0;
        mem_ack = noise && $urandom_range(0, 1) == 1;
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wl = $urandom_range(w_lo, w_hi);
          held = {mem_we, mem_addr, mem_wdata};
        end else chk("addr_hold", {mem_we, mem_addr, mem_wdata}, held);
        if (wl == 0 && !(stall_en && mem_addr == stall_addr)) begin
          mem_ack = 1'b1;
          mem_rdata = mem[mem_addr];
          obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 8'h00});
          if (mem_we) mem[mem_addr] = mem_wdata;
          busy = 1'b0;
        end else if (wl > 0) wl--;
      end
    end
  end
  task automatic run_inst(input logic [7:0] hi, input logic pl, input logic [15:0] tgt,
                          input logic [15:0] e, input logic [15:0] sv, input bit timed);
    logic [15:0] a, ad;
    logic [7:0]  lo, d;
    logic        isd, ram, ind, st, opr;
    int          cyc, exp_cyc;
    a = mpc;
    mem[a] = hi;
    isd = hi[7:6] == 2'b10 && hi[2:1] == 2'b01;
    ram = hi[7] && hi[2:1] == 2'b10;
    ind = hi[7] && hi[2:1] == 2'b11;
    st  = hi[7] && hi[3] && hi[2];
    opr = ram || ind || st;
    exp_q.delete();
    obs_q.delete();
    exp_q.push_back({1'b0, a, 8'h00});
    lo = 8'h00;
    d = 8'h00;
    if (hi[7]) begin
      lo = mem[a + 16'd1];
      exp_q.push_back({1'b0, a + 16'd1, 8'h00});
    end
    if (isd) begin
      d = mem[a + 16'd2];
      exp_q.push_back({1'b0, a + 16'd2, 8'h00});
    end
    ad = e;
    if (ind) begin
      ad = {mem[e + 16'd1], mem[e]};
      exp_q.push_back({1'b0, e, 8'h00});
      exp_q.push_back({1'b0, e + 16'd1, 8'h00});
    end
    if (opr && st) begin
      exp_q.push_back({1'b1, ad, sv[7:0]});
      exp_q.push_back({1'b1, ad + 16'd1, sv[15:8]});
    end else if (opr) begin
      exp_q.push_back({1'b0, ad, 8'h00});
      exp_q.push_back({1'b0, ad + 16'd1, 8'h00});
      m_opnd = {mem[ad + 16'd1], mem[ad]};
    end
    mpc = hi == 8'h02 ? 16'h0010 : pl ? tgt : a + (hi[7] ? 16'd2 : 16'd1) + (isd ? 16'd1 : 16'd0);
    exp_cyc = (hi[7] ? 4 : 3) + (isd ? 1 : 0) + (ind ? 4 : opr ? 2 : 0);
    ea = e;
    store_val = sv;
    pc_load = pl;
    pc_target = tgt;
    run = 1'b1;
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    chk("req_start", mem_req, 1);
    run = 1'b0;
    cyc = 1;
    while (!exec && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("exec_seen", exec, 1);
    chk("dec_en", dec_en, 1);
    if (timed) chk("cycles", cyc, exp_cyc);
    @(negedge clk);
    chk("pc", pc, mpc);
    chk("inst", inst, {hi, lo});
    chk("data", data, d);
    chk("operand", operand, m_opnd);
    chk("exec_pulse", exec, 0);
    chk("nbus", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs_q.size()) chk("bus", obs_q[i], exp_q[i]);
  endtask
  initial begin
    logic [7:0] h;
    rst_n = 1'b0;
    run = 1'b0;
    ea = '0;
    store_val = '0;
    pc_load = 1'b0;
    pc_target = '0;
    noise = 1'b0;
    stall_en = 1'b0;
    stall_addr = '0;
    w_lo = 0;
    w_hi = 0;
    mpc = 16'h0000;
    m_opnd = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_inst", inst, 0);
    chk("rst_data", data, 0);
    chk("rst_operand", operand, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_exec", exec, 0);
    chk("rst_dec_en", dec_en, 0);
    chk("rst_halted", halted, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_inst(8'h00, 1'b1, 16'hFFFE, 16'h0, 16'h0, 1);
    mem[16'hFFFF] = 8'h00;
    mem[16'h0000] = 8'h7F;
    run_inst(8'h82, 1'b0, 16'h0, 16'h0, 16'h0, 1);
    chk("data_7f", data, 8'h7F);
    w_lo = 2;
    w_hi = 2;
    mem[mpc + 16'd1] = 8'h05;
    run_inst(8'h80, 1'b0, 16'h0, 16'h0, 16'h0, 0);
    chk("inst_8005", inst, 16'h8005);
    w_lo = 0;
    w_hi = 0;
    run_inst(8'h00, 1'b1, 16'h0300, 16'h0, 16'h0, 1);
    mem[16'h0020] = 8'h00;
    mem[16'h0021] = 8'h01;
    mem[16'h0100] = 8'h34;
    mem[16'h0101] = 8'h12;
    run_inst(8'h86, 1'b0, 16'h0, 16'h0020, 16'h0, 1);
    chk("operand_1234", operand, 16'h1234);
    run_inst(8'h8C, 1'b0, 16'h0, 16'h0040, 16'hBEEF, 1);
    chk("store_lo", mem[16'h0040], 8'hEF);
    chk("store_hi", mem[16'h0041], 8'hBE);
    run_inst(8'h02, 1'b1, 16'h1234, 16'h0, 16'h0, 1);
    chk("trap_pc", pc, 16'h0010);
    noise = 1'b1;
    w_hi = 3;
    for (int n = 0; n < 60; n++) begin
      if (n == 40) w_hi = 0;
      h = 8'($urandom);
      if (h == 8'h01) h = 8'h00;
      run_inst(h, $urandom_range(0, 3) == 0, 16'($urandom), 16'($urandom), 16'($urandom), n >= 40);
    end
    run_inst(8'h01, 1'b0, 16'h0, 16'h0, 16'h0, 1);
    chk("halt_inst", inst, 16'h0100);
    run = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("halted", halted, 1);
      chk("halt_no_req", mem_req, 0);
    end
    run = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 16'h0000;
    m_opnd = 16'h0000;
    chk("unhalt", halted, 0);
    run_inst(8'h00, 1'b1, 16'h3000, 16'h0, 16'h0, 0);
    mem[16'h3000] = 8'h84;
    stall_addr = 16'h0201;
    stall_en = 1'b1;
    ea = 16'h0200;
    run = 1'b1;
    for (int k = 0; k < 20 && !mem_req; k++) @(negedge clk);
    run = 1'b0;
    for (int k = 0; k < 100 && !(mem_req && mem_addr == 16'h0201); k++) @(negedge clk);
    chk("opr_hi_reached", {mem_req, mem_addr}, {1'b1, 16'h0201});
    #1 rst_n = 1'b0;
    #1;
    chk("rst_drop_req", mem_req, 0);
    chk("rst_mid_pc", pc, 16'h0000);
    chk("rst_mid_exec", exec, 0);
    stall_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_after_rst", mem_req, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
